user_obi_rr_arbiter: RTL
========================

// Module: user_obi_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one OBI subordinate (e.g. the user-domain ROM) among NumMgr OBI managers.
//  Sits between the user-domain managers and a single-outstanding subordinate.
//  Locks one winner per transaction, forwards its A channel and routes the R response back to it.
// PARAMETERS
//  ObiCfg      obi_pkg::ObiDefaultConfig  OBI widths (AddrWidth, DataWidth, IdWidth) for all ports
//  obi_req_t   logic                      OBI request struct
//  obi_rsp_t   logic                      OBI response struct
//  NumMgr      2                          number of managers, >=2
//  TimeoutCyc  16                         response watchdog limit in cycles, >=2 (USER_ARB_TIMEOUT_EN only)
// PORTS
//  clk_i       in   1              clock
//  rst_ni      in   1              reset, synchronous, active-low
//  mgr_req_i   in   NumMgr x req   manager requests
//  mgr_rsp_o   out  NumMgr x rsp   manager responses
//  sbr_req_o   out  req            request to shared subordinate
//  sbr_rsp_i   in   rsp            response from shared subordinate
// BEHAVIOUR
//  Single clock. Reset is synchronous and active-low: on rst_ni=0 at a clk_i edge: state=IDLE, rr_ptr=0, sel_q=0, timer=0.
//  Reset values of outputs: all mgr_rsp_o fields 0, sbr_req_o.req=0, sbr_req_o.a=0.
//  Reset mid-transaction abandons it; no response is returned to the manager. A late sbr rvalid is dropped.
//  FSM IDLE -> REQ -> WAIT -> IDLE:
//   IDLE: scan managers starting at rr_ptr, wrapping modulo NumMgr; the first with req=1 wins.
//         If a winner exists: sel_q<=winner, go to REQ. If none: stay in IDLE. sbr_req_o.req=0 in IDLE.
//   REQ:  sbr_req_o.req=1 and sbr_req_o.a=mgr_req_i[sel_q].a. mgr_rsp_o[sel_q].gnt=sbr_rsp_i.gnt.
//         All other gnt=0. On gnt: rr_ptr<=(sel_q+1) mod NumMgr, go to WAIT.
//   WAIT: sbr_req_o.req=0. On sbr_rsp_i.rvalid, mgr_rsp_o[sel_q].rvalid=1 and .r=sbr_rsp_i.r in the same cycle.
//         Then go to IDLE.
//  Response routing is combinational. Other managers always see rvalid=0 and r=0.
//  Latency: earliest gnt 1 cycle after req is seen in IDLE. Response adds 0 cycles over the subordinate latency.
//  Next arbitration begins the cycle after rvalid.
//  Requests arriving while in REQ or WAIT wait; the locked A channel never changes before gnt (OBI-compliant).
//  Fairness: a manager with req held continuously is granted within NumMgr transactions.
//  rid: the aid is forwarded unchanged and the rid is returned unchanged.
//  sbr_rsp_i.rvalid in IDLE/REQ is ignored. sbr_rsp_i.gnt in IDLE/WAIT is ignored.
// CONFIGURATION
//  USER_ARB_TIMEOUT_EN defined:
//   - timer counts cycles in WAIT; it clears on entry to WAIT.
//   - If timer reaches TimeoutCyc-1 with no rvalid: drive mgr_rsp_o[sel_q].rvalid=1, r.err=1, rdata=0, rid=aid latched at gnt.
//   - Then go to IDLE; a later stale rvalid is dropped.
//  USER_ARB_TIMEOUT_EN undefined: no timer, no aid latch; WAIT lasts until rvalid, unbounded.
// STRUCTURE
//  Package user_arb_pkg: typedef enum logic[1:0] {ARB_IDLE, ARB_REQ, ARB_WAIT} arb_state_e; the MgrIdxW helper function (clog2, min 1).
//  Sub-module user_rr_picker: combinational; inputs req vector and ptr; outputs valid and idx.
//  It searches for the first set bit at or after ptr, wrapping.
//  Top holds the FSM, rr_ptr, sel_q, the optional timer/aid latch and the response mux.
// TESTING
//  1. Only mgr0 reads addr 0x4, subordinate latency 1 -> gnt0 in cycle 2, rvalid0 with rdata one cycle after gnt, mgr1 sees nothing.
//  2. mgr0 and mgr1 hold req for 4 transactions each -> grant order 0,1,0,1,...; never two in a row while both requesting.
//  3. mgr1 asserts req while mgr0 is in REQ with gnt stalled 3 cycles -> sbr addr stays mgr0's; mgr1 is served next.
//  4. Write to subordinate returning err=1, rid=5 -> err and rid=5 appear only on the originating manager.
//  5. rst_ni=0 for one cycle while in WAIT -> next cycle IDLE, rr_ptr=0; a late rvalid produces no manager rvalid.
//  6. USER_ARB_TIMEOUT_EN, TimeoutCyc=16, subordinate never responds -> err response after 16 WAIT cycles; a following request is served normally.

Source files
------------

// File: rtl/user_arb_pkg.sv
// ---------------------------------------------------------------------------
// user_arb_pkg
// Shared types and helpers for the user-domain OBI round-robin arbiter.
//   arb_state_e : arbiter FSM states (IDLE -> REQ -> WAIT -> IDLE)
//   MgrIdxW()   : width of a manager index, clog2(n) with a minimum of 1
// No ports (package).
// ---------------------------------------------------------------------------
package user_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_REQ  = 2'd1,
      ARB_WAIT = 2'd2
   } arb_state_e;

   function automatic int MgrIdxW(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/user_rr_picker.sv
// ---------------------------------------------------------------------------
// user_rr_picker
// Combinational round-robin search: finds the first set bit of req at or
// after ptr, wrapping modulo NumMgr.
// Ports:
//   req   in   NumMgr  request vector
//   ptr   in   IdxW    index where the search starts (must be < NumMgr)
//   valid out  1       at least one request is set
//   idx   out  IdxW    index of the winning request (0 when valid=0)
// ---------------------------------------------------------------------------
module user_rr_picker
   import user_arb_pkg::*;
#(
   parameter int NumMgr = 2,
   parameter int IdxW   = MgrIdxW(NumMgr)
) (
   input  logic [NumMgr-1:0] req,
   input  logic [IdxW-1:0]   ptr,
   output logic              valid,
   output logic [IdxW-1:0]   idx
);

   // cand[gi] is the manager index visited gi steps after ptr.
   logic [IdxW-1:0]   cand [NumMgr];
   logic [NumMgr-1:0] hit;

   for (genvar gi = 0; gi < NumMgr; gi++) begin : g_cand
      logic [IdxW:0] sum;
      assign sum = {1'b0, ptr} + (IdxW+1)'(gi);
      // ptr < NumMgr and gi < NumMgr, so one subtraction is enough to wrap.
      assign cand[gi] = (sum >= (IdxW+1)'(NumMgr)) ? IdxW'(sum - (IdxW+1)'(NumMgr))
                                                   : sum[IdxW-1:0];
      assign hit[gi]  = req[cand[gi]];
   end

   // Walk from the farthest candidate back to ptr so the closest hit wins.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int k = NumMgr - 1; k >= 0; k--) begin
         if (hit[k]) begin
            valid = 1'b1;
            idx   = cand[k];
         end
      end
   end

endmodule

// File: rtl/user_obi_rr_arbiter.sv
// ---------------------------------------------------------------------------
// user_obi_rr_arbiter
// Round-robin arbiter sharing one single-outstanding OBI subordinate among
// NumMgr OBI managers. One winner is locked per transaction; its A channel is
// forwarded while in REQ and the R response is routed back to it in WAIT.
// OBI channels are carried as flattened vectors, manager gi occupying slice
// [gi*W +: W] of each mgr_* bus.
// Optional feature macro: USER_ARB_TIMEOUT_EN -- a response watchdog that
// returns an error response after TimeoutCyc cycles in WAIT.
// Ports:
//   clk_i        in   clock
//   rst_ni       in   synchronous active-low reset
//   mgr_req_i    in   per-manager req
//   mgr_addr_i   in   per-manager addr        (NumMgr x AddrWidth)
//   mgr_we_i     in   per-manager we
//   mgr_be_i     in   per-manager be          (NumMgr x DataWidth/8)
//   mgr_wdata_i  in   per-manager wdata       (NumMgr x DataWidth)
//   mgr_aid_i    in   per-manager aid         (NumMgr x IdWidth)
//   mgr_gnt_o    out  per-manager gnt
//   mgr_rvalid_o out  per-manager rvalid
//   mgr_rdata_o  out  per-manager rdata       (NumMgr x DataWidth)
//   mgr_err_o    out  per-manager err
//   mgr_rid_o    out  per-manager rid         (NumMgr x IdWidth)
//   sbr_req_o / sbr_addr_o / sbr_we_o / sbr_be_o / sbr_wdata_o / sbr_aid_o
//                out  A channel to the shared subordinate
//   sbr_gnt_i / sbr_rvalid_i / sbr_rdata_i / sbr_err_i / sbr_rid_i
//                in   response from the shared subordinate
// ---------------------------------------------------------------------------
module user_obi_rr_arbiter
   import user_arb_pkg::*;
#(
   parameter int NumMgr     = 2,
   parameter int AddrWidth  = 32,
   parameter int DataWidth  = 32,
   parameter int IdWidth    = 4,
   parameter int TimeoutCyc = 16
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic [NumMgr-1:0]               mgr_req_i,
   input  logic [NumMgr*AddrWidth-1:0]     mgr_addr_i,
   input  logic [NumMgr-1:0]               mgr_we_i,
   input  logic [NumMgr*(DataWidth/8)-1:0] mgr_be_i,
   input  logic [NumMgr*DataWidth-1:0]     mgr_wdata_i,
   input  logic [NumMgr*IdWidth-1:0]       mgr_aid_i,
   output logic [NumMgr-1:0]               mgr_gnt_o,
   output logic [NumMgr-1:0]               mgr_rvalid_o,
   output logic [NumMgr*DataWidth-1:0]     mgr_rdata_o,
   output logic [NumMgr-1:0]               mgr_err_o,
   output logic [NumMgr*IdWidth-1:0]       mgr_rid_o,
   output logic                            sbr_req_o,
   output logic [AddrWidth-1:0]            sbr_addr_o,
   output logic                            sbr_we_o,
   output logic [DataWidth/8-1:0]          sbr_be_o,
   output logic [DataWidth-1:0]            sbr_wdata_o,
   output logic [IdWidth-1:0]              sbr_aid_o,
   input  logic                            sbr_gnt_i,
   input  logic                            sbr_rvalid_i,
   input  logic [DataWidth-1:0]            sbr_rdata_i,
   input  logic                            sbr_err_i,
   input  logic [IdWidth-1:0]              sbr_rid_i
);

   localparam int IdxW = MgrIdxW(NumMgr);
   localparam int BeW  = DataWidth / 8;

   arb_state_e      state;
   logic [IdxW-1:0] rr_ptr;
   logic [IdxW-1:0] sel_q;
   logic            pick_valid;
   logic [IdxW-1:0] pick_idx;
   logic            timeout_hit;

   // Per-manager views of the flattened A channel.
   logic [AddrWidth-1:0] addr_arr  [NumMgr];
   logic                 we_arr    [NumMgr];
   logic [BeW-1:0]       be_arr    [NumMgr];
   logic [DataWidth-1:0] wdata_arr [NumMgr];
   logic [IdWidth-1:0]   aid_arr   [NumMgr];

   for (genvar gi = 0; gi < NumMgr; gi++) begin : g_unpack
      assign addr_arr[gi]  = mgr_addr_i[gi*AddrWidth +: AddrWidth];
      assign we_arr[gi]    = mgr_we_i[gi];
      assign be_arr[gi]    = mgr_be_i[gi*BeW +: BeW];
      assign wdata_arr[gi] = mgr_wdata_i[gi*DataWidth +: DataWidth];
      assign aid_arr[gi]   = mgr_aid_i[gi*IdWidth +: IdWidth];
   end

   user_rr_picker #(
      .NumMgr (NumMgr),
      .IdxW   (IdxW)
   ) u_picker (
      .req    (mgr_req_i),
      .ptr    (rr_ptr),
      .valid  (pick_valid),
      .idx    (pick_idx)
   );

`ifdef USER_ARB_TIMEOUT_EN
   localparam int TimerW = (TimeoutCyc > 2) ? $clog2(TimeoutCyc) : 1;
   logic [TimerW-1:0]  timer;
   logic [IdWidth-1:0] aid_q;
   assign timeout_hit = (state == ARB_WAIT) && (timer == TimerW'(TimeoutCyc - 1));
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = TimeoutCyc[0];
   assign timeout_hit        = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state  <= ARB_IDLE;
         rr_ptr <= '0;
         sel_q  <= '0;
`ifdef USER_ARB_TIMEOUT_EN
         timer  <= '0;
         aid_q  <= '0;
`endif
      end else begin
         case (state)
            ARB_IDLE: begin
               if (pick_valid) begin
                  sel_q <= pick_idx;
                  state <= ARB_REQ;
               end
            end
            ARB_REQ: begin
               if (sbr_gnt_i) begin
                  rr_ptr <= (sel_q == IdxW'(NumMgr - 1)) ? '0 : sel_q + IdxW'(1);
                  state  <= ARB_WAIT;
`ifdef USER_ARB_TIMEOUT_EN
                  timer  <= '0;
                  aid_q  <= aid_arr[sel_q];
`endif
               end
            end
            ARB_WAIT: begin
`ifdef USER_ARB_TIMEOUT_EN
               timer <= timer + TimerW'(1);
`endif
               if (sbr_rvalid_i || timeout_hit) begin
                  state <= ARB_IDLE;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   // A channel is only driven while a transaction is locked in REQ, so the
   // subordinate sees zeros otherwise (including during and after reset).
   always_comb begin
      sbr_req_o   = 1'b0;
      sbr_addr_o  = '0;
      sbr_we_o    = 1'b0;
      sbr_be_o    = '0;
      sbr_wdata_o = '0;
      sbr_aid_o   = '0;
      if (state == ARB_REQ) begin
         sbr_req_o   = 1'b1;
         sbr_addr_o  = addr_arr[sel_q];
         sbr_we_o    = we_arr[sel_q];
         sbr_be_o    = be_arr[sel_q];
         sbr_wdata_o = wdata_arr[sel_q];
         sbr_aid_o   = aid_arr[sel_q];
      end
   end

   // Response source: the real subordinate response wins over a watchdog
   // error when both fall in the same cycle.
   logic                 rsp_fire;
   logic [DataWidth-1:0] rsp_rdata;
   logic                 rsp_err;
   logic [IdWidth-1:0]   rsp_rid;

   always_comb begin
      rsp_fire  = 1'b0;
      rsp_rdata = '0;
      rsp_err   = 1'b0;
      rsp_rid   = '0;
      if (state == ARB_WAIT) begin
         if (sbr_rvalid_i) begin
            rsp_fire  = 1'b1;
            rsp_rdata = sbr_rdata_i;
            rsp_err   = sbr_err_i;
            rsp_rid   = sbr_rid_i;
         end
`ifdef USER_ARB_TIMEOUT_EN
         else if (timeout_hit) begin
            rsp_fire = 1'b1;
            rsp_err  = 1'b1;
            rsp_rid  = aid_q;
         end
`endif
      end
   end

   for (genvar gi = 0; gi < NumMgr; gi++) begin : g_route
      logic mine;
      logic fire;
      assign mine = (sel_q == IdxW'(gi));
      assign fire = rsp_fire && mine;
      assign mgr_gnt_o[gi]                          = (state == ARB_REQ) && mine && sbr_gnt_i;
      assign mgr_rvalid_o[gi]                       = fire;
      assign mgr_rdata_o[gi*DataWidth +: DataWidth] = fire ? rsp_rdata : '0;
      assign mgr_err_o[gi]                          = fire && rsp_err;
      assign mgr_rid_o[gi*IdWidth +: IdWidth]       = fire ? rsp_rid : '0;
   end

endmodule
